// File: rtl/key_expansion_seq_if.sv
// rtl/key_expansion_seq_if.sv - column/stream/status bundle for key_expansion_seq (abort port under KEY_EXP_ABORT_EN)
interface key_expansion_seq_if;
  logic [31:0]  First_Coloum;
  logic [31:0]  Second_Coloum;
  logic [31:0]  Third_Coloum;
  logic [31:0]  Last_Coloum;
  logic         start;
  logic [127:0] Round_Key;
  logic [3:0]   Round_Idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;
`ifdef KEY_EXP_ABORT_EN
  logic         abort;

  // key-schedule side
  modport slave (
    input  First_Coloum, Second_Coloum, Third_Coloum, Last_Coloum,
    input  start, rk_ready, abort,
    output Round_Key, Round_Idx, rk_valid, busy, done
  );

  // column source / round-datapath side
  modport master (
    output First_Coloum, Second_Coloum, Third_Coloum, Last_Coloum,
    output start, rk_ready, abort,
    input  Round_Key, Round_Idx, rk_valid, busy, done
  );
`else
  // key-schedule side
  modport slave (
    input  First_Coloum, Second_Coloum, Third_Coloum, Last_Coloum,
    input  start, rk_ready,
    output Round_Key, Round_Idx, rk_valid, busy, done
  );

  // column source / round-datapath side
  modport master (
    output First_Coloum, Second_Coloum, Third_Coloum, Last_Coloum,
    output start, rk_ready,
    input  Round_Key, Round_Idx, rk_valid, busy, done
  );
`endif
endinterface

// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - iterative AES-128 key schedule, one round key per handshake (optional KEY_EXP_ABORT_EN adds abort)
module key_expansion_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input logic               clk,
  input logic               rst,
  key_expansion_seq_if.slave kif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  // FIPS-197 S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q;
  logic [3:0]   idx_q;
  logic [7:0]   rcon_q;
  logic         load_start, load_next;
  logic         valid_o, busy_o, done_o;
  logic         abort_hit;

  logic [31:0]  w0, w1, w2, w3, rot, t;
  logic [31:0]  n0, n1, n2, n3;

  // byte b sits at bit offset 8*(255-b); its MSB index is {~b, 3'b111}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef KEY_EXP_ABORT_EN
  assign abort_hit = kif.abort;
`else
  assign abort_hit = 1'b0;
`endif

  // next round key from the current one; chained XOR form of w[i] = w[i-4] ^ temp
  assign w0  = key_q[127:96];
  assign w1  = key_q[95:64];
  assign w2  = key_q[63:32];
  assign w3  = key_q[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = sub_word(rot) ^ {rcon_q, 24'h000000};
  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state, load strobes and status outputs
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    load_next  = 1'b0;
    valid_o    = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          load_start = 1'b1;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
        if (abort_hit) begin
          state_d = IDLE;
        end else if (kif.rk_ready) begin
          if (idx_q == LAST_IDX) state_d = FIN;
          else                   load_next = 1'b1;
        end
      end
      FIN: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // round key, index and Rcon registers; last key is held after completion or abort
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q  <= '0;
      idx_q  <= '0;
      rcon_q <= 8'h01;
    end else if (load_start) begin
      key_q  <= {kif.First_Coloum, kif.Second_Coloum, kif.Third_Coloum, kif.Last_Coloum};
      idx_q  <= '0;
      rcon_q <= 8'h01;
    end else if (load_next) begin
      key_q  <= {n0, n1, n2, n3};
      idx_q  <= idx_q + 4'd1;
      rcon_q <= xtime(rcon_q);
    end
  end

  assign kif.Round_Key = key_q;
  assign kif.Round_Idx = idx_q;
  assign kif.rk_valid  = valid_o;
  assign kif.busy      = busy_o;
  assign kif.done      = done_o;

endmodule
